// File: rtl/countdown_32_pkg.sv
// Shared types for the loadable down-counter.
// State encodings and the default counter width.
package countdown_32_pkg;

  localparam int CD_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_32_dec_chain.sv
// Combinational borrow-chain decrementer: y = a - 1 (mod 2^WIDTH).
// Ports: a (operand), y (result). Bit i toggles when all lower bits are 0.
module dec_chain #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] borrow;

  always_comb begin
    borrow[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      y[i]          = a[i] ^ borrow[i];
      borrow[i + 1] = borrow[i] & ~a[i];
    end
  end

endmodule

// File: rtl/countdown_32.sv
// Loadable down-counter with one-cycle done pulse and optional auto-reload.
// Ports: clock, reset (sync, active-high), load/load_val/en in; q, zero, busy, done out.
module countdown_32
  import countdown_32_pkg::*;
#(
  parameter int WIDTH       = CD_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic [WIDTH-1:0] q_dec;

  dec_chain #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a(q_q),
    .y(q_dec)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    if (load) begin
      q_d     = load_val;
      rld_d   = load_val;
      state_d = (load_val == '0) ? ST_DONE : ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (en) begin
            // Stop at one so the decrement never wraps past zero.
            if (q_q <= WIDTH'(1)) begin
              q_d     = '0;
              state_d = ST_DONE;
            end else begin
              q_d = q_dec;
            end
          end
        end
        ST_DONE: begin
          if (AUTO_RELOAD && (rld_q != '0)) begin
            q_d     = rld_q;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      rld_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_32.sv
// Testbench for countdown_32: table vectors, corner sequences, random vs model.
// Two instances share stimulus: AUTO_RELOAD=0 (u0) and AUTO_RELOAD=1 (u1).
module tb_countdown_32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;
  logic       en = 1'b0;
  logic [4:0] q0, q1;
  logic       zero0, zero1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  // Model: remaining count, phase (0 idle, 1 counting, 2 finished), reload.
  int m_cnt[2];
  int m_ph[2];
  int m_rl[2];

  always #5 clock = ~clock;

  countdown_32 #(.WIDTH(5), .AUTO_RELOAD(1'b0)) u0 (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val),
    .en(en), .q(q0), .zero(zero0), .busy(busy0), .done(done0)
  );

  countdown_32 #(.WIDTH(5), .AUTO_RELOAD(1'b1)) u1 (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val),
    .en(en), .q(q1), .zero(zero1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_cnt[d] = 0; m_ph[d] = 0; m_rl[d] = 0;
      end else if (load) begin
        m_cnt[d] = int'(load_val);
        m_rl[d]  = int'(load_val);
        m_ph[d]  = (load_val == 0) ? 2 : 1;
      end else if (m_ph[d] == 1) begin
        if (en) begin
          m_cnt[d] = m_cnt[d] - 1;
          if (m_cnt[d] == 0) m_ph[d] = 2;
        end
      end else if (m_ph[d] == 2) begin
        if (d == 1 && m_rl[d] > 0) begin
          m_cnt[d] = m_rl[d];
          m_ph[d]  = 1;
        end else begin
          m_ph[d] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("m0_q", int'(q0), m_cnt[0]);
    chk("m0_zero", int'(zero0), int'(m_cnt[0] == 0));
    chk("m0_busy", int'(busy0), int'(m_ph[0] == 1));
    chk("m0_done", int'(done0), int'(m_ph[0] == 2));
    chk("m1_q", int'(q1), m_cnt[1]);
    chk("m1_zero", int'(zero1), int'(m_cnt[1] == 0));
    chk("m1_busy", int'(busy1), int'(m_ph[1] == 1));
    chk("m1_done", int'(done1), int'(m_ph[1] == 2));
  endtask

  task automatic drive(input bit r, input bit l, input int v, input bit e);
    reset    = r;
    load     = l;
    load_val = 5'(v);
    en       = e;
  endtask

  typedef struct {
    bit rst; bit ld; int lv; bit en;
    int q; bit busy; bit done;
  } vec_t;

  vec_t vt[$];
  int   pulses;

  initial begin
    vt = '{
      '{1, 1, 9, 1, 0, 0, 0},
      '{1, 1, 9, 1, 0, 0, 0},
      '{0, 1, 5, 1, 5, 1, 0},
      '{0, 0, 0, 1, 4, 1, 0},
      '{0, 0, 0, 1, 3, 1, 0},
      '{0, 0, 0, 1, 2, 1, 0},
      '{0, 0, 0, 1, 1, 1, 0},
      '{0, 0, 0, 1, 0, 0, 1},
      '{0, 0, 0, 1, 0, 0, 0},
      '{0, 0, 0, 1, 0, 0, 0},
      '{0, 1, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0}
    };
    #1;
    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].ld, vt[i].lv, vt[i].en);
      step();
      chk($sformatf("tbl%0d_q", i), int'(q0), vt[i].q);
      chk($sformatf("tbl%0d_zero", i), int'(zero0), int'(vt[i].q == 0));
      chk($sformatf("tbl%0d_busy", i), int'(busy0), int'(vt[i].busy));
      chk($sformatf("tbl%0d_done", i), int'(done0), int'(vt[i].done));
    end

    // Pause then restart mid-count.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 10, 1); step();
    chk("pr_load", int'(q0), 10);
    drive(0, 0, 0, 1);
    repeat (3) step();
    chk("pr_q7", int'(q0), 7);
    drive(0, 0, 0, 0);
    repeat (4) begin
      step();
      chk("pr_hold", int'(q0), 7);
      chk("pr_hold_busy", int'(busy0), 1);
    end
    drive(0, 1, 3, 1); step();
    chk("pr_reload", int'(q0), 3);
    chk("pr_busy", int'(busy0), 1);
    drive(0, 0, 0, 1);
    for (int k = 2; k >= 1; k--) begin
      step();
      chk("pr_cnt", int'(q0), k);
      chk("pr_nodone", int'(done0), 0);
    end
    step();
    chk("pr_end_q", int'(q0), 0);
    chk("pr_end_done", int'(done0), 1);
    chk("pr_end_busy", int'(busy0), 0);

    // Full-range load: 31 decrements, one pulse, no wrap.
    drive(0, 1, 31, 1); step();
    chk("max_load", int'(q0), 31);
    drive(0, 0, 0, 1);
    pulses = 0;
    for (int k = 30; k >= 0; k--) begin
      step();
      chk("max_cnt", int'(q0), k);
      if (done0) pulses++;
    end
    repeat (3) begin
      step();
      chk("max_stay0", int'(q0), 0);
      if (done0) pulses++;
    end
    chk("max_pulses", pulses, 1);

    // Auto-reload on u1, then reset mid-count.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 2, 1); step();
    chk("ar_q2", int'(q1), 2);
    drive(0, 0, 0, 1);
    repeat (2) begin
      step(); chk("ar_q1", int'(q1), 1);
      step(); chk("ar_q0", int'(q1), 0);
      chk("ar_done", int'(done1), 1);
      chk("ar_notbusy", int'(busy1), 0);
      step(); chk("ar_again", int'(q1), 2);
      chk("ar_busy", int'(busy1), 1);
    end
    step(); chk("ar_mid", int'(q1), 1);
    drive(1, 0, 0, 1); step();
    chk("ar_rst_q", int'(q1), 0);
    chk("ar_rst_done", int'(done1), 0);
    drive(0, 0, 0, 1);
    repeat (3) begin
      step();
      chk("ar_idle_done", int'(done1), 0);
      chk("ar_idle_busy", int'(busy1), 0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 31)), $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) load_val = 5'($urandom_range(0, 2));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
